// File: rtl/piso_tx_ctrl_pkg.sv
// Shared definitions for the PISO transmit controller: state encoding, default width and
// bit-counter sizing.
package piso_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StShift = 2'd2,
    StGap   = 2'd3
  } state_e;

  localparam int unsigned DefaultWidth = 4;
  localparam int unsigned DefaultCntW  = $clog2(DefaultWidth);

  // Keeps the bit counter at least one bit wide so WIDTH=1 still elaborates.
  function automatic int unsigned cnt_width(int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_tx_ctrl_if.sv
// Producer handshake plus PISO-facing and status signals of the transmit controller.
interface piso_tx_ctrl_if
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) ();

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             s_lbar;
  logic [WIDTH-1:0] din;
  logic             bit_valid;
  logic             frame_start;
  logic             frame_end;
  logic             busy;
  logic [7:0]       words_sent;

  modport master (
    output in_valid, in_data,
    input  in_ready, s_lbar, din, bit_valid, frame_start, frame_end, busy, words_sent
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, s_lbar, din, bit_valid, frame_start, frame_end, busy, words_sent
  );

endinterface

// File: rtl/piso_tx_ctrl.sv
// Sequences an external PISO through LOAD, SHIFT and optional GAP phases, with a one-word
// hold buffer in front of it and a wrapping count of completed frames.
module piso_tx_ctrl
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned GAP   = 0
) (
  input logic           clk,
  input logic           rst,
  piso_tx_ctrl_if.slave bus
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             pend_v_q, pend_v_d;
  logic [7:0]       words_q, words_d;
  logic             push;

  // The LOAD cycle frees the buffer, so a new word may be accepted alongside the pop.
  assign bus.in_ready = !rst && (!pend_v_q || state_q == StLoad);
  assign push         = bus.in_valid && bus.in_ready;

  always_comb begin
    hold_d    = push ? bus.in_data : hold_q;
    pend_v_d  = pend_v_q;
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    words_d   = words_q;

    if (push) begin
      pend_v_d = 1'b1;
    end else if (state_q == StLoad) begin
      pend_v_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (pend_v_d) state_d = StLoad;
      end
      StLoad: begin
        state_d   = StShift;
        bit_cnt_d = CntW'(WIDTH - 1);
      end
      StShift: begin
        if (bit_cnt_q == '0) begin
          words_d = words_q + 8'd1;
          if (GAP > 0) begin
            state_d   = StGap;
            gap_cnt_d = 4'(GAP - 1);
          end else begin
            state_d = pend_v_d ? StLoad : StIdle;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      StGap: begin
        if (gap_cnt_q == 4'd0) begin
          state_d = pend_v_d ? StLoad : StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      hold_q    <= '0;
      pend_v_q  <= 1'b0;
      words_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      hold_q    <= hold_d;
      pend_v_q  <= pend_v_d;
      words_q   <= words_d;
    end
  end

  assign bus.s_lbar      = (state_q != StLoad);
  assign bus.din         = hold_q;
  assign bus.bit_valid   = (state_q == StShift);
  assign bus.frame_start = (state_q == StShift) && (bit_cnt_q == CntW'(WIDTH - 1));
  assign bus.frame_end   = (state_q == StShift) && (bit_cnt_q == '0);
  assign bus.busy        = (state_q != StIdle);
  assign bus.words_sent  = words_q;

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Two controllers (GAP=0 and GAP=2) each feeding a behavioural PISO; accepted words are
// scheduled into expected LOAD/bit queues that a negedge monitor drains and compares.
module tb_piso_tx_ctrl;

  localparam int W  = 4;
  localparam int G0 = 0;
  localparam int G1 = 2;

  typedef struct {
    int         n;
    int         l;
    logic [W-1:0] w;
  } ld_t;

  typedef struct {
    int   c;
    logic b;
    logic s;
    logic e;
  } bit_t;

  logic clk = 1'b0;
  logic rst;
  logic valid;
  logic [W-1:0] data;
  int   cyc = 0;

  int n_cmp = 0;
  int n_err = 0;

  ld_t  ldq [2][$];
  bit_t bitq[2][$];
  int   last_e[2];
  int   done[2];
  int   busy_until[2];
  logic armed = 1'b0;
  logic rst_prev = 1'b0;

  piso_tx_ctrl_if #(.WIDTH(W)) bus0 ();
  piso_tx_ctrl_if #(.WIDTH(W)) bus1 ();

  assign bus0.in_valid = valid;
  assign bus0.in_data  = data;
  assign bus1.in_valid = valid;
  assign bus1.in_data  = data;

  piso_tx_ctrl #(.WIDTH(W), .GAP(G0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  piso_tx_ctrl #(.WIDTH(W), .GAP(G1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural PISOs following the load/shift contract.
  logic [W-1:0] sh0, sh1;
  always @(posedge clk) begin
    sh0 <= !bus0.s_lbar ? bus0.din : {sh0[W-2:0], 1'b0};
    sh1 <= !bus1.s_lbar ? bus1.din : {sh1[W-2:0], 1'b0};
  end

  task automatic chk(input int d, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d cycle %0d: got %0h, expected %0h", name, d, cyc, act, exp);
    end
  endtask

  // Schedules an accepted word: its LOAD is the later of the acceptance edge and the end of
  // the previous frame plus gap; its bits follow MSB first.
  task automatic accept(input int d, input int gap, input logic ir);
    ld_t  ld;
    bit_t ev;
    int   earliest;
    if (valid && ir) begin
      ld.n     = cyc + 1;
      earliest = last_e[d] + 1 + gap;
      ld.l     = (ld.n > earliest) ? ld.n : earliest;
      ld.w     = data;
      ldq[d].push_back(ld);
      for (int i = 0; i < W; i++) begin
        ev.c = ld.l + 1 + i;
        ev.b = data[W-1-i];
        ev.s = (i == 0);
        ev.e = (i == W - 1);
        bitq[d].push_back(ev);
      end
      last_e[d] = ld.l + W;
    end
  endtask

  task automatic check_dut(input int d, input int gap, input logic ir, input logic sl,
                           input logic [W-1:0] dn, input logic bv, input logic fs,
                           input logic fe, input logic bsy, input logic [7:0] ws,
                           input logic q);
    logic pend;
    logic exp_load;
    logic exp_bit;
    bit_t ev;
    pend = 1'b0;
    for (int i = 0; i < ldq[d].size(); i++) begin
      if (ldq[d][i].n <= cyc && cyc < ldq[d][i].l) pend = 1'b1;
    end
    chk(d, "in_ready", {31'd0, ir}, {31'd0, !rst && !pend});
    if (rst_prev) begin
      chk(d, "rst_s_lbar", {31'd0, sl}, 32'd1);
      chk(d, "rst_bit_valid", {31'd0, bv}, 32'd0);
      chk(d, "rst_frame_flags", {30'd0, fs, fe}, 32'd0);
      chk(d, "rst_busy", {31'd0, bsy}, 32'd0);
      chk(d, "rst_words_sent", {24'd0, ws}, 32'd0);
      chk(d, "rst_din", {28'd0, dn}, 32'd0);
    end else begin
      exp_load = (ldq[d].size() > 0) && (ldq[d][0].l == cyc);
      chk(d, "s_lbar", {31'd0, sl}, {31'd0, !exp_load});
      if (exp_load) begin
        chk(d, "din", {28'd0, dn}, {28'd0, ldq[d][0].w});
        void'(ldq[d].pop_front());
        busy_until[d] = cyc + W + gap;
      end
      chk(d, "busy", {31'd0, bsy}, {31'd0, exp_load || (cyc <= busy_until[d])});
      chk(d, "words_sent", {24'd0, ws}, {24'd0, 8'(done[d])});
      exp_bit = (bitq[d].size() > 0) && (bitq[d][0].c == cyc);
      chk(d, "bit_valid", {31'd0, bv}, {31'd0, exp_bit});
      if (exp_bit) begin
        ev = bitq[d].pop_front();
        chk(d, "q_out", {31'd0, q}, {31'd0, ev.b});
        chk(d, "frame_start", {31'd0, fs}, {31'd0, ev.s});
        chk(d, "frame_end", {31'd0, fe}, {31'd0, ev.e});
        if (ev.e) done[d]++;
      end else begin
        chk(d, "idle_frame_flags", {30'd0, fs, fe}, 32'd0);
      end
    end
  endtask

  // Expected-response producer: watches accepted transfers.
  always @(negedge clk) begin
    if (rst) begin
      last_e[0] = -100;
      last_e[1] = -100;
    end else begin
      accept(0, G0, bus0.in_ready);
      accept(1, G1, bus1.in_ready);
    end
  end

  // Monitor: compares the DUT outputs against the scheduled expectations.
  always @(negedge clk) begin
    if (armed) begin
      check_dut(0, G0, bus0.in_ready, bus0.s_lbar, bus0.din, bus0.bit_valid,
                bus0.frame_start, bus0.frame_end, bus0.busy, bus0.words_sent, sh0[W-1]);
      check_dut(1, G1, bus1.in_ready, bus1.s_lbar, bus1.din, bus1.bit_valid,
                bus1.frame_start, bus1.frame_end, bus1.busy, bus1.words_sent, sh1[W-1]);
    end
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        ldq[d].delete();
        bitq[d].delete();
        done[d]       = 0;
        busy_until[d] = -1;
      end
      armed = 1'b1;
    end
    rst_prev = rst;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    last_e[0] = -100;
    last_e[1] = -100;
    valid = 1'b0;
    data  = '0;
    rst   = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    // Single word.
    valid = 1'b1;
    data  = 4'b1011;
    step();
    valid = 1'b0;
    repeat (12) step();

    // Back-to-back words with valid held high.
    valid = 1'b1;
    data  = 4'b0110;
    step();
    data = 4'b1111;
    repeat (12) step();
    valid = 1'b0;
    repeat (15) step();

    // Reset after two bits of a frame, with a second word pending.
    valid = 1'b1;
    data  = 4'b1011;
    step();
    data = 4'b0101;
    step();
    valid = 1'b0;
    step();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (10) step();

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      valid = ($urandom_range(0, 3) != 0);
      data  = W'($urandom);
      rst   = ($urandom_range(0, 79) == 0);
      step();
      if (rst) begin
        step();
        rst = 1'b0;
      end
    end
    rst = 1'b0;

    // Saturated traffic, long enough for words_sent to wrap on both instances.
    valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      data = W'($urandom);
      step();
    end
    valid = 1'b0;
    repeat (20) step();

    for (int d = 0; d < 2; d++) begin
      chk(d, "drain_loads", 32'(ldq[d].size()), 32'd0);
      chk(d, "drain_bits", 32'(bitq[d].size()), 32'd0);
      chk(d, "frames_past_wrap", {31'd0, done[d] >= 256}, 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/piso_tx_ctrl.md
# piso_tx_ctrl

Sequencing controller for the 4-bit parallel-in/serial-out shift register. It accepts parallel words over a valid/ready handshake and buffers one word. It drives the PISO's shift/load-bar and parallel data inputs through a LOAD → SHIFT → optional GAP sequence, and flags which cycles carry valid serial bits. It sits between a word producer and a PISO instance that the parent module instantiates alongside it.

## Interface
- WIDTH, default 4: word width; must match the PISO width.
- GAP, default 0: idle cycles inserted after each frame (0–15).
- clk  in  1  rising-edge clock, shared with the PISO.
- rst  in  1  one clock; reset is synchronous and active-high.
- in_valid  in  1  producer has a word on in_data.
- in_data  in  WIDTH  parallel word; the MSB is serialised first.
- in_ready  out  1  controller can take a word this cycle.
- s_lbar  out  1  to the PISO: 0 = load din at the edge, 1 = shift one place toward q_out.
- din  out  WIDTH  to the PISO parallel input.
- bit_valid  out  1  the PISO q_out carries a data bit this cycle.
- frame_start  out  1  first data bit of a frame (MSB).
- frame_end  out  1  last data bit of a frame (LSB).
- busy  out  1  state is not IDLE.
- words_sent  out  8  count of completed frames; wraps modulo 256.

## Operation
- PISO contract: at an edge with s_lbar=0 the PISO loads din, and q_out then shows din[WIDTH-1]. Each edge with s_lbar=1 shifts the next lower bit onto q_out.
- Hold register: one entry (hold, pend_v). A transfer occurs when in_valid && in_ready. The transfer writes hold and sets pend_v.
- in_ready = !rst && (!pend_v || state==LOAD). A simultaneous pop and push in the LOAD cycle is legal; pend_v stays 1 and hold takes the new word.
- din = hold at all times. s_lbar = 0 only in LOAD and 1 in every other state.
- States:
  - IDLE: go to LOAD if pend_v is set or a transfer occurs this edge.
  - LOAD: 1 cycle. At the edge, pop hold (pend_v clears unless a push occurs), load bit_cnt = WIDTH-1, go to SHIFT.
  - SHIFT: WIDTH cycles. bit_valid=1. frame_start=1 when bit_cnt==WIDTH-1. frame_end=1 when bit_cnt==0. bit_cnt decrements each cycle.
  - Leaving SHIFT, at the edge where bit_cnt==0: words_sent increments. If GAP>0, go to GAP with gap_cnt=GAP-1. Otherwise go to LOAD if pend_v is set (after any push at that edge), else IDLE.
  - GAP: bit_valid=0. When gap_cnt==0, go to LOAD if pend_v is set, else IDLE. Otherwise decrement gap_cnt.
- Reset mid-operation: state=IDLE, pend_v=0 (the buffered word is discarded), counters cleared. A frame in progress is abandoned; no frame_end is issued for it.
- Reset values, valid in the cycle after the reset edge: s_lbar=1, bit_valid=0, frame_start=0, frame_end=0, busy=0, words_sent=0, pend_v=0, din=0. in_ready is 0 while rst is high and 1 in the first cycle after.

## Timing
- Transfer at edge T from IDLE: LOAD occupies cycle T+1 with din equal to the word. Data bits appear on q_out in cycles T+2 … T+1+WIDTH, MSB first.
- Frame period: 1 + WIDTH + GAP cycles. With GAP=0 and pend_v set, LOAD directly follows the frame_end cycle with no idle cycle between frames.
- For WIDTH=1, frame_start and frame_end are asserted in the same cycle.
- All outputs except in_ready are registered or decoded from registered state only. in_ready depends on rst, pend_v and state.

## Structure
- Shared package piso_pkg:
  - state encoding localparams (IDLE, LOAD, SHIFT, GAP; 2 bits);
  - default WIDTH=4;
  - counter width, clog2 of WIDTH.
- Single module; no sub-module is needed. The PISO itself is instantiated by the parent, not inside this block.

## Test plan
1. Reset: hold rst high 2 cycles mid-traffic → s_lbar=1, bit_valid=0, in_ready=0 during reset and 1 in the next cycle, words_sent=0.
2. Single word 4'b1011 accepted at edge T, GAP=0 → s_lbar=0 and din=1011 in T+1; q_out=1,0,1,1 with bit_valid over T+2..T+5; frame_start at T+2, frame_end at T+5; words_sent=1; busy=0 at T+6.
3. Back-to-back 4'b0110 then 4'b1111, in_valid held high, GAP=0 → second word pushed during the LOAD cycle of the first; second LOAD immediately after the first frame_end; serial stream 0,1,1,0,1,1,1,1 over 8 valid cycles with one LOAD cycle between frames; in_ready low while pend_v=1 outside LOAD.
4. GAP=2, two words queued → exactly 2 cycles with bit_valid=0 and s_lbar=1 between frame_end and the next LOAD.
5. rst asserted after 2 bits of 4'b1011, with a second word pending → next cycle IDLE, bit_valid=0, pend_v=0, no frame_end, words_sent=0.
6. 256 frames sent → words_sent wraps 255→0 at the edge that completes frame 256.
